axis_32to8: RTL and testbench
=============================

AXIS_32TO8 -- requirements
Module: axis_32to8

Interface
REQ-001 Parameter: PKT_CNT_W, default 16, width of the packet counter.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
REQ-004 axis_tdata_in  input  32  input word; lane i = bits [8i+7:8i].
REQ-005 axis_tkeep_in  input  4  per-lane byte valid.
REQ-006 axis_tvalid_in  input  1  input word valid.
REQ-007 axis_tlast_in  input  1  word ends the packet.
REQ-008 axis_tready_out  output  1  block accepts the input word.
REQ-009 axis_tdata_out  output  8  output byte.
REQ-010 axis_tvalid_out  output  1  output byte valid.
REQ-011 axis_tlast_out  output  1  final byte of the packet.
REQ-012 axis_tready_in  input  1  downstream accepts the byte.
REQ-013 err_keep  output  1  one-cycle pulse when a word with tkeep=0000 is accepted.
REQ-014 pkt_cnt  output  PKT_CNT_W  count of packets emitted (tlast bytes transferred).

Function
REQ-015 An input transfer occurs when axis_tvalid_in && axis_tready_out; an output transfer occurs when axis_tvalid_out && axis_tready_in.
REQ-016 Bytes of a word are emitted from the highest kept lane down to lane 0, skipping lanes whose keep bit is 0; a full word emits [31:24] first and [7:0] last.
REQ-017 Partial final words are right-aligned (keep 0001/0011/0111); they emit 1/2/3 bytes, highest kept lane first.
REQ-018 axis_tlast_out is 1 only on the last emitted byte of a word accepted with axis_tlast_in=1.
REQ-019 Storage: one active-word register plus one skid register; each holds data, keep, and last.
REQ-020 States: EMPTY (no word), BUSY (active only), FULL (active + skid).
REQ-021 EMPTY->BUSY on input transfer. BUSY->FULL on input transfer without the active word's final byte transferring. BUSY->EMPTY on the final byte transferring with no input. FULL->BUSY on the final byte transferring; the skid word becomes active in the same cycle.
REQ-022 BUSY with final-byte transfer and input transfer in the same cycle: the new word loads directly into the active register and the state stays BUSY.
REQ-023 axis_tready_out is registered, equals "next state != FULL", and has no combinational path from axis_tready_in.
REQ-024 Latency: a word accepted in cycle N presents its first byte with axis_tvalid_out=1 in cycle N+1.
REQ-025 Sustained throughput is 1 byte/cycle with no bubble between consecutive words.
REQ-026 While axis_tvalid_out=1 and axis_tready_in=0, axis_tdata_out and axis_tlast_out hold stable.
REQ-027 A word with tkeep=0000 is accepted, emits nothing, and pulses err_keep in the next cycle.
REQ-028 If a tkeep=0000 word carries tlast=1, the packet end is lost and pkt_cnt does not increment.
REQ-029 pkt_cnt increments on each output transfer with axis_tlast_out=1 and wraps modulo 2^PKT_CNT_W.

Reset
REQ-030 While reset_n=0: state=EMPTY, axis_tready_out=0, axis_tvalid_out=0, axis_tlast_out=0, axis_tdata_out=0, err_keep=0, pkt_cnt=0.
REQ-031 axis_tready_out rises on the first clk edge after reset_n deasserts.
REQ-032 Reset asserted mid-packet discards all buffered bytes; no partial word is emitted after reset is released.

Structure
REQ-033 Shared package axis_pkg holds LANES=4, KEEP_W=4, and the state encoding (EMPTY/BUSY/FULL).
REQ-034 One sub-module, axis_skid_reg (the registered-ready skid buffer), is natural; lane selection and counting stay in axis_32to8.

Verification
REQ-035 Full word 0xA1B2C3D4, keep=1111, last=1, tready_in=1 -> bytes A1,B2,C3,D4 in cycles N+1..N+4, tlast only on D4, pkt_cnt=1.
REQ-036 Back-to-back words 0x00010203 then 0x04050607 keep=0111 last=1 -> bytes 00,01,02,03,05,06,07 in 7 consecutive cycles, tlast on 07.
REQ-037 Downstream tready_in toggles 1,0,0,1 during word 0x11223344 -> each byte held stable while stalled, no loss or duplication, and axis_tready_out=0 only when FULL.
REQ-038 Word keep=0000, last=1, then word 0xAABBCCDD keep=0001 last=1 -> err_keep pulses once, only DD is emitted (with tlast), pkt_cnt=1.
REQ-039 reset_n pulled low after 2 bytes of a 4-byte word -> outputs zero immediately, remaining bytes never appear, tready_out=1 one cycle after release.
REQ-040 PKT_CNT_W=4, send 17 one-byte packets -> pkt_cnt reads 1 (wrap-around).

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types for the 32-to-8 AXI-Stream width converter: lane geometry,
// buffer state encoding, the stored word record and a lane-priority helper.
package axis_pkg;

    localparam int LANES  = 4;
    localparam int KEEP_W = 4;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [8*LANES-1:0] data;
        logic [KEEP_W-1:0]  keep;
        logic               last;
    } word_t;

    // Index of the highest set keep bit; lane 0 when nothing is kept.
    function automatic logic [LANE_W-1:0] highest_lane(input logic [KEEP_W-1:0] keep);
        highest_lane = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (keep[i]) highest_lane = LANE_W'(i);
        end
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Active-word register plus one skid register behind a registered ready.
// The active word's keep shrinks as its bytes are emitted by the parent.
module axis_skid_reg
    import axis_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  word_t             push_word,
    input  logic              pop,
    input  logic              upd,
    input  logic [KEEP_W-1:0] upd_keep,
    output word_t             act_word,
    output logic              act_valid,
    output logic              ready
);

    state_t state_q, state_d;
    word_t  act_q, act_d;
    word_t  skid_q, skid_d;
    logic   ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        skid_d  = skid_q;
        if (upd) act_d.keep = upd_keep;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    act_d   = push_word;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Final byte leaving while a new word arrives: load straight
                // into the active register so the byte stream has no bubble.
                if (pop && push) begin
                    act_d = push_word;
                end else if (pop) begin
                    state_d = EMPTY;
                end else if (push) begin
                    skid_d  = push_word;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (pop) begin
                    act_d   = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            act_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign act_word  = act_q;
    assign act_valid = (state_q != EMPTY);
    assign ready     = ready_q;

endmodule

// File: rtl/axis_32to8.sv
// 32-bit to 8-bit AXI-Stream width converter: emits kept lanes highest first,
// flags all-zero keep words and counts emitted packets.
module axis_32to8
    import axis_pkg::*;
#(
    parameter int PKT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          axis_tdata_in,
    input  logic [3:0]           axis_tkeep_in,
    input  logic                 axis_tvalid_in,
    input  logic                 axis_tlast_in,
    output logic                 axis_tready_out,
    output logic [7:0]           axis_tdata_out,
    output logic                 axis_tvalid_out,
    output logic                 axis_tlast_out,
    input  logic                 axis_tready_in,
    output logic                 err_keep,
    output logic [PKT_CNT_W-1:0] pkt_cnt
);

    word_t               in_word, act_word;
    logic                act_valid, ready;
    logic                in_xfer, out_xfer, push, pop, upd, final_byte;
    logic [LANE_W-1:0]   hi_lane;
    logic [KEEP_W-1:0]   keep_left;
    logic                err_keep_q, err_keep_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        in_word.data = axis_tdata_in;
        in_word.keep = axis_tkeep_in;
        in_word.last = axis_tlast_in;

        hi_lane              = highest_lane(act_word.keep);
        keep_left            = act_word.keep;
        keep_left[hi_lane]   = 1'b0;
        final_byte           = (keep_left == '0);

        in_xfer  = axis_tvalid_in && ready;
        out_xfer = act_valid && axis_tready_in;
        // Empty-keep words are consumed here and never reach the buffer.
        push     = in_xfer && (axis_tkeep_in != '0);
        pop      = out_xfer && final_byte;
        upd      = out_xfer && !final_byte;

        err_keep_d = in_xfer && (axis_tkeep_in == '0);
        pkt_cnt_d  = pkt_cnt_q;
        if (pop && act_word.last) pkt_cnt_d = pkt_cnt_q + 1'b1;
    end

    axis_skid_reg u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_word (in_word),
        .pop       (pop),
        .upd       (upd),
        .upd_keep  (keep_left),
        .act_word  (act_word),
        .act_valid (act_valid),
        .ready     (ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_keep_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            err_keep_q <= err_keep_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign axis_tready_out = ready;
    assign axis_tvalid_out = act_valid;
    assign axis_tdata_out  = act_word.data[{hi_lane, 3'b000} +: 8];
    assign axis_tlast_out  = act_valid && final_byte && act_word.last;
    assign err_keep        = err_keep_q;
    assign pkt_cnt         = pkt_cnt_q;

endmodule

// File: tb/tb_axis_32to8.sv
// Directed bench for axis_32to8: linear steps, hand-computed byte sequences.
module tb_axis_32to8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] axis_tdata_in;
    logic [3:0]  axis_tkeep_in;
    logic        axis_tvalid_in;
    logic        axis_tlast_in;
    logic        axis_tready_out;
    logic [7:0]  axis_tdata_out;
    logic        axis_tvalid_out;
    logic        axis_tlast_out;
    logic        axis_tready_in;
    logic        err_keep;
    logic [3:0]  pkt_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_32to8 #(.PKT_CNT_W(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .axis_tdata_in   (axis_tdata_in),
        .axis_tkeep_in   (axis_tkeep_in),
        .axis_tvalid_in  (axis_tvalid_in),
        .axis_tlast_in   (axis_tlast_in),
        .axis_tready_out (axis_tready_out),
        .axis_tdata_out  (axis_tdata_out),
        .axis_tvalid_out (axis_tvalid_out),
        .axis_tlast_out  (axis_tlast_out),
        .axis_tready_in  (axis_tready_in),
        .err_keep        (err_keep),
        .pkt_cnt         (pkt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the byte presented in the current cycle, then advance one cycle.
    task automatic exp_byte(input string tag, input logic [7:0] d, input logic l);
        $display("byte %s data=%02h last=%0d", tag, axis_tdata_out, axis_tlast_out);
        chk({tag, "_valid"}, {31'd0, axis_tvalid_out}, 32'd1);
        chk({tag, "_data"},  {24'd0, axis_tdata_out}, {24'd0, d});
        chk({tag, "_last"},  {31'd0, axis_tlast_out}, {31'd0, l});
        tick();
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
        axis_tdata_in  = d;
        axis_tkeep_in  = k;
        axis_tlast_in  = l;
        axis_tvalid_in = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        axis_tdata_in  = '0;
        axis_tkeep_in  = '0;
        axis_tvalid_in = 1'b0;
        axis_tlast_in  = 1'b0;
        axis_tready_in = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_ready", {31'd0, axis_tready_out}, 32'd0);
        chk("rst_valid", {31'd0, axis_tvalid_out}, 32'd0);
        chk("rst_last",  {31'd0, axis_tlast_out}, 32'd0);
        chk("rst_data",  {24'd0, axis_tdata_out}, 32'd0);
        chk("rst_err",   {31'd0, err_keep}, 32'd0);
        chk("rst_pkt",   {28'd0, pkt_cnt}, 32'd0);
        reset_n = 1'b1;
        chk("rel_ready0", {31'd0, axis_tready_out}, 32'd0);
        tick();
        chk("rel_ready1", {31'd0, axis_tready_out}, 32'd1);

        // Full word, single-beat packet
        $display("step full_word");
        drive(32'hA1B2C3D4, 4'b1111, 1'b1);
        tick();
        axis_tvalid_in = 1'b0;
        exp_byte("fw0", 8'hA1, 1'b0);
        exp_byte("fw1", 8'hB2, 1'b0);
        exp_byte("fw2", 8'hC3, 1'b0);
        exp_byte("fw3", 8'hD4, 1'b1);
        chk("fw_idle", {31'd0, axis_tvalid_out}, 32'd0);
        chk("fw_pkt",  {28'd0, pkt_cnt}, 32'd1);

        // Back-to-back words; second is partial, skid fills then drains
        $display("step back_to_back");
        drive(32'h00010203, 4'b1111, 1'b0);
        tick();
        drive(32'h04050607, 4'b0111, 1'b1);
        chk("b2b_ready_busy", {31'd0, axis_tready_out}, 32'd1);
        exp_byte("b2b0", 8'h00, 1'b0);
        axis_tvalid_in = 1'b0;
        chk("b2b_ready_full", {31'd0, axis_tready_out}, 32'd0);
        exp_byte("b2b1", 8'h01, 1'b0);
        exp_byte("b2b2", 8'h02, 1'b0);
        chk("b2b_ready_full2", {31'd0, axis_tready_out}, 32'd0);
        exp_byte("b2b3", 8'h03, 1'b0);
        chk("b2b_ready_back", {31'd0, axis_tready_out}, 32'd1);
        exp_byte("b2b4", 8'h05, 1'b0);
        exp_byte("b2b5", 8'h06, 1'b0);
        exp_byte("b2b6", 8'h07, 1'b1);
        chk("b2b_idle", {31'd0, axis_tvalid_out}, 32'd0);
        chk("b2b_pkt",  {28'd0, pkt_cnt}, 32'd2);

        // Downstream stall pattern 1,0,0,1
        $display("step stall");
        drive(32'h11223344, 4'b1111, 1'b1);
        tick();
        axis_tvalid_in = 1'b0;
        exp_byte("st0", 8'h11, 1'b0);
        axis_tready_in = 1'b0;
        chk("st_ready_busy", {31'd0, axis_tready_out}, 32'd1);
        exp_byte("st1a", 8'h22, 1'b0);
        exp_byte("st1b", 8'h22, 1'b0);
        axis_tready_in = 1'b1;
        exp_byte("st1c", 8'h22, 1'b0);
        exp_byte("st2", 8'h33, 1'b0);
        exp_byte("st3", 8'h44, 1'b1);
        chk("st_idle", {31'd0, axis_tvalid_out}, 32'd0);
        chk("st_pkt",  {28'd0, pkt_cnt}, 32'd3);

        // Empty-keep word with tlast, then a one-byte packet
        $display("step empty_keep");
        drive(32'hDEADBEEF, 4'b0000, 1'b1);
        tick();
        chk("ek_err",   {31'd0, err_keep}, 32'd1);
        chk("ek_valid", {31'd0, axis_tvalid_out}, 32'd0);
        drive(32'hAABBCCDD, 4'b0001, 1'b1);
        tick();
        axis_tvalid_in = 1'b0;
        chk("ek_err_once", {31'd0, err_keep}, 32'd0);
        exp_byte("ek0", 8'hDD, 1'b1);
        chk("ek_idle", {31'd0, axis_tvalid_out}, 32'd0);
        chk("ek_pkt",  {28'd0, pkt_cnt}, 32'd4);

        // Reset mid-word
        $display("step mid_reset");
        drive(32'h55667788, 4'b1111, 1'b1);
        tick();
        axis_tvalid_in = 1'b0;
        exp_byte("mr0", 8'h55, 1'b0);
        exp_byte("mr1", 8'h66, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, axis_tvalid_out}, 32'd0);
        chk("mr_data",  {24'd0, axis_tdata_out}, 32'd0);
        chk("mr_last",  {31'd0, axis_tlast_out}, 32'd0);
        chk("mr_ready", {31'd0, axis_tready_out}, 32'd0);
        chk("mr_pkt",   {28'd0, pkt_cnt}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("mr_ready_up", {31'd0, axis_tready_out}, 32'd1);
        chk("mr_no_resid", {31'd0, axis_tvalid_out}, 32'd0);
        tick();
        chk("mr_no_resid2", {31'd0, axis_tvalid_out}, 32'd0);

        // Seventeen one-byte packets wrap a 4-bit counter to 1
        $display("step wrap");
        drive(32'h00000000, 4'b0001, 1'b1);
        tick();
        for (int i = 1; i < 17; i++) begin
            drive(32'(i), 4'b0001, 1'b1);
            chk("wr_ready", {31'd0, axis_tready_out}, 32'd1);
            exp_byte("wr", 8'(i - 1), 1'b1);
        end
        axis_tvalid_in = 1'b0;
        exp_byte("wr_last", 8'd16, 1'b1);
        chk("wr_idle", {31'd0, axis_tvalid_out}, 32'd0);
        chk("wr_pkt",  {28'd0, pkt_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
